// File: rtl/stream_pool_layer.sv
// Streaming k x k max/average pooling over all channels in parallel, feeding an
// output FIFO toward the next layer and pulsing o_done once per frame.
module stream_pool_layer #(
    parameter int input_channels       = 5,
    parameter int img_width            = 24,
    parameter int kernel_dim           = 2,
    parameter int datatype_size        = 4,
    parameter int output_datatype_size = 4,
    parameter int out_fifo_depth       = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                i_start,
    input  logic                                                i_mode,
    input  logic                                                i_ibuf_we,
    input  logic [input_channels-1:0][datatype_size-1:0]        i_ibuf_wr_data,
    output logic                                                o_ready,
    output logic                                                o_busy,
    input  logic                                                i_next_busy,
    output logic                                                o_valid,
    output logic [input_channels-1:0][output_datatype_size-1:0] o_func_data,
    output logic                                                o_done
);
    localparam int out_dim = img_width / kernel_dim;
    localparam int k_log   = $clog2(kernel_dim);
    localparam int acc_w   = datatype_size + 2 * k_log;
    localparam int pos_w   = $clog2(img_width + 1);
    localparam int idx_w   = (out_dim > 1) ? $clog2(out_dim) : 1;
    localparam int ptr_w   = $clog2(out_fifo_depth);
    localparam int cnt_w   = $clog2(out_fifo_depth + 1);

    localparam logic [pos_w-1:0] pos_last = pos_w'(img_width - 1);
    localparam logic [pos_w-1:0] pos_used = pos_w'(out_dim * kernel_dim);
    localparam logic [k_log-1:0] sub_last = '1;
    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(out_fifo_depth - 1);
    localparam logic [cnt_w-1:0] cnt_full = cnt_w'(out_fifo_depth);
    localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef logic [input_channels-1:0][acc_w-1:0]                acc_vec_t;
    typedef logic [input_channels-1:0][output_datatype_size-1:0] out_vec_t;

    state_t           state, state_nx;
    logic             mode_q;
    logic [pos_w-1:0] row, col;
    logic [ptr_w-1:0] wr_ptr, rd_ptr;
    logic [cnt_w-1:0] count;
    logic             done_nx;

    acc_vec_t acc      [out_dim];
    out_vec_t fifo_mem [out_fifo_depth];

    logic             start_ok, accept, in_range, win_first, win_last, push, pop, drain_empty;
    logic [idx_w-1:0] win_idx;
    acc_vec_t         px_ext, acc_nx;
    logic [input_channels-1:0][datatype_size-1:0] res_px;
    out_vec_t         push_data;

    assign start_ok    = (state == IDLE) && i_start;
    assign o_ready     = (state == RUN) && (count < cnt_full);
    assign o_busy      = (state != IDLE);
    assign o_valid     = (count != '0);
    assign accept      = i_ibuf_we && o_ready;
    assign in_range    = (row < pos_used) && (col < pos_used);
    assign win_first   = (row[k_log-1:0] == '0) && (col[k_log-1:0] == '0);
    assign win_last    = (row[k_log-1:0] == sub_last) && (col[k_log-1:0] == sub_last);
    assign win_idx     = idx_w'(col >> k_log);
    assign push        = accept && in_range && win_last;
    assign pop         = o_valid && !i_next_busy;
    assign drain_empty = (count == '0) || ((count == cnt_one) && pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        px_ext = '0;
        acc_nx = '0;
        res_px = '0;
        for (int c = 0; c < input_channels; c++) begin
            px_ext[c] = acc_w'(i_ibuf_wr_data[c]);
            if (win_first)
                acc_nx[c] = px_ext[c];
            else if (mode_q)
                acc_nx[c] = acc[win_idx][c] + px_ext[c];
            else
                acc_nx[c] = (px_ext[c] > acc[win_idx][c]) ? px_ext[c] : acc[win_idx][c];
            // The shifted average can never exceed the input range.
            res_px[c] = mode_q ? datatype_size'(acc_nx[c] >> (2 * k_log))
                               : datatype_size'(acc_nx[c]);
        end
    end

    if (output_datatype_size >= datatype_size) begin : g_zext
        always_comb begin
            push_data = '0;
            for (int c = 0; c < input_channels; c++)
                push_data[c] = output_datatype_size'(res_px[c]);
        end
    end else begin : g_sat
        localparam logic [datatype_size-1:0] sat_max =
            datatype_size'((1 << output_datatype_size) - 1);
        always_comb begin
            push_data = '0;
            for (int c = 0; c < input_channels; c++)
                push_data[c] = (res_px[c] > sat_max) ? '1 : output_datatype_size'(res_px[c]);
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        unique case (state)
            IDLE:    if (i_start) state_nx = RUN;
            RUN:     if (accept && (row == pos_last) && (col == pos_last)) state_nx = DRAIN;
            DRAIN:   if (drain_empty) begin
                         state_nx = IDLE;
                         done_nx  = 1'b1;
                     end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            row    <= '0;
            col    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nx;
            o_done <= done_nx;
            if (start_ok) begin
                mode_q <= i_mode;
                row    <= '0;
                col    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (accept) begin
                    if (col == pos_last) begin
                        col <= '0;
                        row <= (row == pos_last) ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                if (push) wr_ptr <= (wr_ptr == ptr_last) ? '0 : wr_ptr + 1'b1;
                if (pop)  rd_ptr <= (rd_ptr == ptr_last) ? '0 : rd_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
        end
    end

    // NOTE: storage arrays carry no reset; window starts reload acc and o_valid gates the FIFO head.
    always_ff @(posedge clk) begin
        if (accept && in_range) acc[win_idx] <= acc_nx;
        if (push)               fifo_mem[wr_ptr] <= push_data;
    end

    assign o_func_data = o_valid ? fifo_mem[rd_ptr] : '0;

endmodule
